// File: rtl/bitrev_frame_buffer.sv
// Ping-pong frame buffer between the windowing stage and the FFT core. Frames are written in
// bit-reversed order when FFT_BITREV_EN is defined (natural order otherwise) and read out naturally.
module bitrev_frame_buffer #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_en,
  input  logic [WIDTH-1:0] din_re,
  input  logic [WIDTH-1:0] din_im,
  input  logic [3:0]       n_fft_log2,
  input  logic             clr_ovf,
  input  logic             dout_ready,
  output logic             dout_en,
  output logic [WIDTH-1:0] dout_re,
  output logic [WIDTH-1:0] dout_im,
  output logic             dout_sof,
  output logic             dout_eof,
  output logic             overflow
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, STREAM} rd_state_e;

  logic [2*WIDTH-1:0] mem [2][DEPTH];

  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [3:0]        ncur_q, ncur_d;
  logic              wbank_q, wbank_d;
  logic              drop_q, drop_d;
  logic [1:0]        full_q, full_d;
  logic [1:0][3:0]   nlen_q, nlen_d;
  logic              overflow_q, overflow_d;

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rcnt_q, rcnt_d;
  logic              rbank_q, rbank_d;
  logic              en_q, en_d;
  logic [WIDTH-1:0]  re_q, re_d, im_q, im_d;
  logic              sof_q, sof_d, eof_q, eof_d;

  logic              frameStart, frameLast, dropNow, wrEn, ovfSet;
  logic [3:0]        nEff;
  logic [ADDR_W:0]   wOneHot, rOneHot;
  logic [ADDR_W-1:0] wMask, rMask, wrAddr;
  logic [1:0]        fullSet, fullClr;
  logic [2*WIDTH-1:0] rdWord;
`ifdef FFT_BITREV_EN
  logic [ADDR_W-1:0] wRevFull;
  logic [4:0]        revShift;
`endif

  // Write-side decode: the frame length and drop decision are taken from the live inputs on the
  // first sample of a frame, and from the latched copies for the rest of it.
  always_comb begin
    frameStart = (wcnt_q == '0);
    nEff       = frameStart ? n_fft_log2 : ncur_q;
    dropNow    = frameStart ? full_q[wbank_q] : drop_q;
    wOneHot    = (ADDR_W+1)'(1) << nEff;
    wMask      = wOneHot[ADDR_W-1:0] - ADDR_W'(1);
    frameLast  = (wcnt_q == wMask);
    wrEn       = din_en && !dropNow;
`ifdef FFT_BITREV_EN
    for (int i = 0; i < ADDR_W; i++) begin
      wRevFull[i] = wcnt_q[ADDR_W-1-i];
    end
    // Reversing all ADDR_W bits and shifting down leaves only the low nEff bits reversed.
    revShift = 5'(ADDR_W) - {1'b0, nEff};
    wrAddr   = wRevFull >> revShift;
`else
    wrAddr   = wcnt_q;
`endif
  end

  always_comb begin
    wcnt_d  = wcnt_q;
    ncur_d  = ncur_q;
    wbank_d = wbank_q;
    drop_d  = drop_q;
    nlen_d  = nlen_q;
    fullSet = 2'b00;
    ovfSet  = 1'b0;
    if (din_en) begin
      if (frameStart) begin
        ncur_d = n_fft_log2;
        drop_d = full_q[wbank_q];
      end
      if (frameLast) begin
        wcnt_d = '0;
        if (dropNow) begin
          ovfSet = 1'b1;
          drop_d = 1'b0;
        end else begin
          fullSet[wbank_q] = 1'b1;
          nlen_d[wbank_q]  = ncur_q;
          wbank_d          = !wbank_q;
        end
      end else begin
        wcnt_d = wcnt_q + ADDR_W'(1);
      end
    end
  end

  // Read FSM: the output register reloads whenever it is empty or being accepted, so a stall
  // simply freezes it and frame alignment is never lost.
  always_comb begin
    rOneHot = (ADDR_W+1)'(1) << nlen_q[rbank_q];
    rMask   = rOneHot[ADDR_W-1:0] - ADDR_W'(1);
    rdWord  = mem[rbank_q][rcnt_q];
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    fullClr = 2'b00;
    en_d    = en_q;
    re_d    = re_q;
    im_d    = im_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    case (state_q)
      IDLE: begin
        if (dout_ready) begin
          en_d  = 1'b0;
          sof_d = 1'b0;
          eof_d = 1'b0;
        end
        if (full_q[rbank_q]) begin
          state_d = STREAM;
          rcnt_d  = '0;
        end
      end
      STREAM: begin
        if (!en_q || dout_ready) begin
          en_d         = 1'b1;
          {re_d, im_d} = rdWord;
          sof_d        = (rcnt_q == '0);
          eof_d        = (rcnt_q == rMask);
          rcnt_d       = rcnt_q + ADDR_W'(1);
          if (rcnt_q == rMask) begin
            fullClr[rbank_q] = 1'b1;
            rbank_d          = !rbank_q;
            state_d          = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    full_d     = (full_q | fullSet) & ~fullClr;
    overflow_d = ovfSet ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wbank_q][wrAddr] <= {din_re, din_im};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q     <= '0;
      ncur_q     <= '0;
      wbank_q    <= 1'b0;
      drop_q     <= 1'b0;
      full_q     <= 2'b00;
      nlen_q     <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      rcnt_q     <= '0;
      rbank_q    <= 1'b0;
      en_q       <= 1'b0;
      re_q       <= '0;
      im_q       <= '0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
    end else begin
      wcnt_q     <= wcnt_d;
      ncur_q     <= ncur_d;
      wbank_q    <= wbank_d;
      drop_q     <= drop_d;
      full_q     <= full_d;
      nlen_q     <= nlen_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      rbank_q    <= rbank_d;
      en_q       <= en_d;
      re_q       <= re_d;
      im_q       <= im_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
    end
  end

  assign dout_en  = en_q;
  assign dout_re  = re_q;
  assign dout_im  = im_q;
  assign dout_sof = sof_q;
  assign dout_eof = eof_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bitrev_frame_buffer.sv
// Bench for bitrev_frame_buffer: directed and random frames scored against a queue model of the
// expected output stream (order derived from the sample index reversal rule).
`timescale 1ns/1ps
module tb_bitrev_frame_buffer;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             din_en;
  logic [WIDTH-1:0] din_re, din_im;
  logic [3:0]       n_fft_log2;
  logic             clr_ovf;
  logic             dout_ready;
  logic             dout_en;
  logic [WIDTH-1:0] dout_re, dout_im;
  logic             dout_sof, dout_eof;
  logic             overflow;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic        sof;
    logic        eof;
  } word_t;

  word_t       expQ[$];
  logic [15:0] obsLog[$];
  int          errors = 0;
  int          checks = 0;
  int          outstanding = 0;
  int          readyMode = 0;
  logic        holdValid = 1'b0;
  logic [33:0] held = '0;

  bitrev_frame_buffer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .din_en(din_en), .din_re(din_re), .din_im(din_im),
    .n_fft_log2(n_fft_log2), .clr_ovf(clr_ovf), .dout_ready(dout_ready),
    .dout_en(dout_en), .dout_re(dout_re), .dout_im(dout_im),
    .dout_sof(dout_sof), .dout_eof(dout_eof), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int bitrev(input int v, input int n);
    int r = 0;
    for (int i = 0; i < n; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  // Output slot p carries the input sample whose write address is p.
  function automatic int srcIndex(input int p, input int n);
`ifdef FFT_BITREV_EN
    return bitrev(p, n);
`else
    return p + 0 * n;
`endif
  endfunction

  // Ready driver: 0 always ready, 1 never, 2 pattern 1,0,0,1, otherwise random.
  initial begin
    int phase = 0;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: dout_ready = 1'b1;
        1: dout_ready = 1'b0;
        2: begin
          dout_ready = (phase % 4 == 0) || (phase % 4 == 3);
          phase++;
        end
        default: dout_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Compare process: every accepted word against the model, plus stability while stalled.
  initial begin
    word_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        holdValid = 1'b0;
        continue;
      end
      if (holdValid) begin
        checkOutput("stall_en", 64'(dout_en), 64'(1));
        checkOutput("stall_hold", 64'({dout_re, dout_im, dout_sof, dout_eof}), 64'(held));
      end
      if (dout_en && dout_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got %0h expected none at %0t", dout_re, $time);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_word", 64'({dout_re, dout_im, dout_sof, dout_eof}), 64'(e));
          if (e.eof) outstanding--;
        end
        obsLog.push_back(dout_re);
      end
      holdValid = dout_en && !dout_ready;
      held      = {dout_re, dout_im, dout_sof, dout_eof};
    end
  end

  // Drives samples 0..stopAt-1 (whole frame if stopAt<0); the last one is left on the pins.
  task automatic applyStimulus(input int n, input int mode, input bit gaps, input bit jitterN,
                               input bit expectDrop, input int stopAt);
    logic [15:0] sRe [1024];
    logic [15:0] sIm [1024];
    int len = 1 << n;
    int cnt = (stopAt < 0) ? len : stopAt;
    word_t w;
    for (int k = 0; k < cnt; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
          din_en = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      sRe[k]     = (mode == 0) ? 16'(k) : 16'($urandom);
      sIm[k]     = (mode == 0) ? ~16'(k) : 16'($urandom);
      din_en     = 1'b1;
      din_re     = sRe[k];
      din_im     = sIm[k];
      n_fft_log2 = (k == 0 || !jitterN) ? 4'(n) : 4'($urandom_range(3, ADDR_W));
    end
    if (!expectDrop && cnt == len) begin
      for (int p = 0; p < len; p++) begin
        w.re  = sRe[srcIndex(p, n)];
        w.im  = sIm[srcIndex(p, n)];
        w.sof = (p == 0);
        w.eof = (p == len - 1);
        expQ.push_back(w);
      end
      outstanding++;
    end
  endtask

  task automatic idleCycles(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
      din_en = 1'b0;
    end
  endtask

  task automatic waitDrain(input string name, input int limit);
    int c = 0;
    while ((expQ.size() != 0 || dout_en) && c < limit) begin
      idleCycles(1);
      c++;
    end
    checkOutput(name, 64'(expQ.size() == 0 && !dout_en), 64'(1));
  endtask

  task automatic waitOutstanding(input int maxFrames, input int limit);
    int c = 0;
    while (outstanding > maxFrames && c < limit) begin
      idleCycles(1);
      c++;
    end
    checkOutput("pace_wait", 64'(outstanding <= maxFrames), 64'(1));
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_flags"}, 64'({dout_en, dout_sof, dout_eof, overflow}), 64'(0));
    checkOutput({name, "_data"}, 64'({dout_re, dout_im}), 64'(0));
  endtask

  task automatic flushModel();
    expQ.delete();
    outstanding = 0;
    din_en      = 1'b0;
  endtask

  task automatic checkOrder(input string name);
    logic [15:0] expLit [8];
`ifdef FFT_BITREV_EN
    expLit = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
`else
    expLit = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
`endif
    checkOutput({name, "_len"}, 64'(obsLog.size()), 64'(8));
    for (int i = 0; i < 8 && i < obsLog.size(); i++) begin
      checkOutput({name, "_word"}, 64'(obsLog[i]), 64'(expLit[i]));
    end
  endtask

  initial begin
    rst_n = 1'b0; din_en = 1'b0; din_re = '0; din_im = '0;
    n_fft_log2 = 4'd3; clr_ovf = 1'b0; dout_ready = 1'b0;
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    checkOutput("model_rev_1_n3", 64'(bitrev(1, 3)), 64'(4));
    checkOutput("model_rev_3_n3", 64'(bitrev(3, 3)), 64'(6));
    checkOutput("model_rev_1_n4", 64'(bitrev(1, 4)), 64'(8));

    // Basic frame and latency.
    readyMode = 0;
    idleCycles(2);
    obsLog.delete();
    applyStimulus(3, 0, 1'b0, 1'b0, 1'b0, -1);
    @(posedge clk);
    #1;
    din_en = 1'b0;
    @(negedge clk);
    checkOutput("latency_t0", 64'(dout_en), 64'(0));
    @(negedge clk);
    checkOutput("latency_t1", 64'(dout_en), 64'(0));
    @(negedge clk);
    checkOutput("latency_t2", 64'({dout_en, dout_sof}), 64'(2'b11));
    waitDrain("drain_basic", 200);
    checkOrder("order_basic");

    // Backpressure.
    readyMode = 2;
    obsLog.delete();
    applyStimulus(3, 0, 1'b0, 1'b0, 1'b0, -1);
    waitDrain("drain_bp", 400);
    checkOrder("order_bp");

    // Overflow: two frames buffered, third dropped.
    readyMode = 1;
    idleCycles(3);
    applyStimulus(4, 1, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(4, 1, 1'b0, 1'b0, 1'b0, -1);
    idleCycles(1);
    checkOutput("ovf_before_drop", 64'(overflow), 64'(0));
    applyStimulus(4, 1, 1'b0, 1'b0, 1'b1, -1);
    idleCycles(1);
    checkOutput("ovf_set", 64'(overflow), 64'(1));
    readyMode = 0;
    waitDrain("drain_ovf", 400);
    checkOutput("ovf_sticky", 64'(overflow), 64'(1));
    @(posedge clk);
    #1;
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    checkOutput("ovf_clear", 64'(overflow), 64'(0));

    // Length change between back-to-back frames.
    applyStimulus(3, 1, 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(4, 1, 1'b0, 1'b0, 1'b0, -1);
    waitDrain("drain_len", 400);

    // Reset mid-frame while a stalled word sits in the output register.
    readyMode = 1;
    idleCycles(2);
    applyStimulus(3, 0, 1'b0, 1'b0, 1'b0, -1);
    idleCycles(4);
    checkOutput("pre_reset_en", 64'(dout_en), 64'(1));
    applyStimulus(4, 1, 1'b0, 1'b0, 1'b0, 5);
    @(posedge clk);
    #1;
    din_en = 1'b1;
    din_re = 16'h1234;
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rst_midframe");
    flushModel();
    idleCycles(2);
    #2;
    rst_n = 1'b1;

    // Reset while streaming.
    readyMode = 0;
    idleCycles(2);
    applyStimulus(4, 1, 1'b0, 1'b0, 1'b0, -1);
    begin
      int c = 0;
      while (!dout_en && c < 50) begin
        idleCycles(1);
        c++;
      end
      checkOutput("stream_started", 64'(dout_en), 64'(1));
    end
    idleCycles(3);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rst_stream");
    flushModel();
    idleCycles(2);
    #2;
    rst_n = 1'b1;
    idleCycles(1);
    applyStimulus(4, 1, 1'b0, 1'b0, 1'b0, -1);
    waitDrain("drain_after_reset", 400);

    // Random frames: gaps, random ready, n_fft_log2 wiggled mid-frame.
    readyMode = 3;
    for (int f = 0; f < 40; f++) begin
      waitOutstanding(1, 2000);
      applyStimulus($urandom_range(3, 6), 1, 1'b1, 1'b1, 1'b0, -1);
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 5));
    end
    idleCycles(1);
    readyMode = 0;
    waitDrain("drain_random", 3000);
    checkOutput("ovf_random", 64'(overflow), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
